// File: rtl/bandit_pkg.sv
// bandit_pkg: shared types and constants for the bandit environment.
//   action_t  - arm index (8 bits, 256 arms)
//   reward_t  - reward value (16 bits)
//   prob_t    - hit probability, unsigned, 16'hFFFF means always hit
//   LFSR_TAPS - Galois feedback mask for the right-shifting 16-bit LFSR
//   state_t   - environment FSM states
package bandit_pkg;

    typedef logic [7:0]  action_t;
    typedef logic [15:0] reward_t;
    typedef logic [15:0] prob_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_DRAW,
        ST_RESPOND
    } state_t;

endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Galois LFSR, shifting right, feedback mask LFSR_TAPS.
//   clock - rising-edge clock
//   reset - asynchronous active-high, loads SEED
//   step  - advance the sequence by one position this edge
//   value - current LFSR state
// A nonzero SEED never reaches zero: each step is an invertible map that
// sends zero to zero, so no other state can map onto it.
module lfsr16
    import bandit_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        step,
    output logic [15:0] value
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= SEED;
        end else if (step) begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/bandit_environment.sv
// bandit_environment: multi-armed bandit reward source.
// An accepted arm selection steps the LFSR, reads that arm's hit
// probability from a 256-entry table, and returns REWARD when the LFSR
// value is <= the probability, otherwise zero.
//   clock, reset                 - rising-edge clock, async active-high reset
//   action_valid/ready/data      - arm selection handshake (8-bit arm)
//   reward_valid/ready/data      - reward handshake (16-bit reward)
//   config_valid/ready/addr/data - probability table write port
// Optional build macro BANDIT_ENV_STATS_EN adds pull_count (accepted
// actions) and reward_total (sum of handshaken rewards), both 32-bit wrapping.
module bandit_environment
    import bandit_pkg::*;
#(
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter logic [15:0] REWARD = 16'h7FFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        action_valid,
    input  logic [7:0]  action_data,
    output logic        action_ready,
    output logic        reward_valid,
    output logic [15:0] reward_data,
    input  logic        reward_ready,
    input  logic        config_valid,
    input  logic [7:0]  config_addr,
    input  logic [15:0] config_data,
    output logic        config_ready
`ifdef BANDIT_ENV_STATS_EN
    ,
    output logic [31:0] pull_count,
    output logic [31:0] reward_total
`endif
);

    state_t  state, state_nxt;
    action_t arm_p0;
    prob_t   prob_p1;
    prob_t   prob_mem [256];
    logic [15:0] lfsr_value;
    logic    accept;
    logic    draw_hit;

    assign accept   = action_valid && action_ready;
    assign draw_hit = (lfsr_value <= prob_p1);

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .step  (accept),
        .value (lfsr_value)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ready/valid are decoded from state so an async reset drops
    // reward_valid immediately.
    always_comb begin
        state_nxt    = state;
        action_ready = 1'b0;
        config_ready = 1'b0;
        reward_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                action_ready = 1'b1;
                config_ready = 1'b1;
                if (action_valid) begin
                    state_nxt = ST_LOOKUP;
                end
            end
            ST_LOOKUP: state_nxt = ST_DRAW;
            ST_DRAW:   state_nxt = ST_RESPOND;
            ST_RESPOND: begin
                reward_valid = 1'b1;
                if (reward_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage p0: latch the selected arm on acceptance.
    always_ff @(posedge clock) begin
        if (accept) begin
            arm_p0 <= action_data;
        end
    end

    // Table write only happens in IDLE, so a write accepted alongside an
    // action lands one edge before the LOOKUP read and is seen by it.
    always_ff @(posedge clock) begin
        if (config_valid && config_ready) begin
            prob_mem[config_addr] <= config_data;
        end
    end

    // Stage p1: synchronous table read for the latched arm.
    always_ff @(posedge clock) begin
        if (state == ST_LOOKUP) begin
            prob_p1 <= prob_mem[arm_p0];
        end
    end

    // Stage p2: draw the reward; held stable through RESPOND.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reward_data <= 16'h0000;
        end else if (state == ST_DRAW) begin
            reward_data <= draw_hit ? REWARD : 16'h0000;
        end
    end

`ifdef BANDIT_ENV_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pull_count   <= 32'd0;
            reward_total <= 32'd0;
        end else begin
            if (accept) begin
                pull_count <= pull_count + 32'd1;
            end
            if (reward_valid && reward_ready) begin
                reward_total <= reward_total + {16'h0000, reward_data};
            end
        end
    end
`endif

endmodule

// File: tb/tb_bandit_environment.sv
// Testbench for bandit_environment: directed steps plus randomized arms and
// probabilities, checked against a reference model of the LFSR draw.
// Build with BANDIT_ENV_STATS_EN to also check the statistics counters.
module tb_bandit_environment;

    localparam logic [15:0] SEED   = 16'hACE1;
    localparam logic [15:0] REWARD = 16'h7FFF;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        action_valid = 1'b0;
    logic [7:0]  action_data = 8'h00;
    logic        action_ready;
    logic        reward_valid;
    logic [15:0] reward_data;
    logic        reward_ready = 1'b0;
    logic        config_valid = 1'b0;
    logic [7:0]  config_addr = 8'h00;
    logic [15:0] config_data = 16'h0000;
    logic        config_ready;
`ifdef BANDIT_ENV_STATS_EN
    logic [31:0] pull_count;
    logic [31:0] reward_total;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [15:0] prob_m [256];
    logic [15:0] lfsr_m;
    logic [31:0] pulls_m;
    logic [31:0] total_m;

    bandit_environment #(.SEED(SEED), .REWARD(REWARD)) dut (
        .clock        (clock),
        .reset        (reset),
        .action_valid (action_valid),
        .action_data  (action_data),
        .action_ready (action_ready),
        .reward_valid (reward_valid),
        .reward_data  (reward_data),
        .reward_ready (reward_ready),
        .config_valid (config_valid),
        .config_addr  (config_addr),
        .config_data  (config_data),
        .config_ready (config_ready)
`ifdef BANDIT_ENV_STATS_EN
        ,
        .pull_count   (pull_count),
        .reward_total (reward_total)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // One LFSR step as arithmetic: halve, and xor the taps in when odd.
    function automatic logic [15:0] model_step(input logic [15:0] v);
        int unsigned x;
        x = int'(v) / 2;
        if (v % 2 == 1) x = x ^ 32'h0000_B400;
        return x[15:0];
    endfunction

    task automatic model_reset;
        lfsr_m  = SEED;
        pulls_m = 0;
        total_m = 0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic [15:0] data);
        config_valid = 1'b1;
        config_addr  = addr;
        config_data  = data;
        chk("cfg_ready", config_ready, 1);
        tick();
        config_valid = 1'b0;
        prob_m[addr] = data;
    endtask

    // Accept one action, check latency, optionally stall, then either
    // complete the reward handshake or reset the DUT mid-RESPOND.
    task automatic run_action(input logic [7:0] arm, input int stall,
                              input bit do_cfg, input logic [7:0] caddr,
                              input logic [15:0] cdata, input bit abort);
        logic [15:0] exp;
        if (do_cfg) begin
            config_valid = 1'b1;
            config_addr  = caddr;
            config_data  = cdata;
        end
        action_valid = 1'b1;
        action_data  = arm;
        reward_ready = 1'b0;
        chk("idle_action_ready", action_ready, 1);
        if (do_cfg) chk("idle_config_ready", config_ready, 1);
        tick();  // acceptance edge
        action_valid = 1'b0;
        config_valid = 1'b0;
        if (do_cfg) prob_m[caddr] = cdata;
        lfsr_m  = model_step(lfsr_m);
        pulls_m = pulls_m + 1;
        exp = (lfsr_m <= prob_m[arm]) ? REWARD : 16'h0000;
        chk("lookup_reward_valid", reward_valid, 0);
        chk("lookup_action_ready", action_ready, 0);
        chk("lookup_config_ready", config_ready, 0);
        tick();
        chk("draw_reward_valid", reward_valid, 0);
        tick();
        chk("respond_reward_valid", reward_valid, 1);
        chk("reward_data", reward_data, exp);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_reward_valid", reward_valid, 1);
            chk("stall_reward_data", reward_data, exp);
            chk("stall_action_ready", action_ready, 0);
        end
        if (abort) begin
            #2;
            reset = 1'b1;
            #1;
            chk("async_reset_reward_valid", reward_valid, 0);
            chk("async_reset_reward_data", reward_data, 0);
            tick();
            reset = 1'b0;
            model_reset();
        end else begin
            reward_ready = 1'b1;
            tick();
            reward_ready = 1'b0;
            total_m = total_m + {16'h0000, exp};
            chk("post_reward_valid", reward_valid, 0);
            chk("post_action_ready", action_ready, 1);
        end
`ifdef BANDIT_ENV_STATS_EN
        chk("pull_count", pull_count, pulls_m);
        chk("reward_total", reward_total, total_m);
`endif
    endtask

    initial begin
        logic [7:0]  arm;
        logic [15:0] p;

        model_reset();
        do_reset();
        chk("reset_action_ready", action_ready, 1);
        chk("reset_config_ready", config_ready, 1);
        chk("reset_reward_valid", reward_valid, 0);
        chk("reset_reward_data", reward_data, 0);

        // Always-hit arm
        cfg_write(8'd5, 16'hFFFF);
        run_action(8'd5, 0, 1'b0, 8'd0, 16'h0, 1'b0);
        chk("always_hit_data", reward_data, 16'h7FFF);

        // Never-hit arm, ten pulls
        cfg_write(8'd9, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            run_action(8'd9, 0, 1'b0, 8'd0, 16'h0, 1'b0);
            chk("never_hit_data", reward_data, 16'h0000);
        end

        // Downstream stall of 20 cycles in RESPOND
        run_action(8'd5, 20, 1'b0, 8'd0, 16'h0, 1'b0);

        // Same-edge table write and action on the same arm
        cfg_write(8'd3, 16'h0000);
        run_action(8'd3, 0, 1'b1, 8'd3, 16'hFFFF, 1'b0);
        chk("same_cycle_cfg_data", reward_data, 16'h7FFF);

        // Randomized arms and probabilities over arms 16..31
        for (int a = 16; a < 32; a++) begin
            case ($urandom_range(0, 3))
                0: p = 16'h0000;
                1: p = 16'hFFFF;
                default: p = 16'($urandom);
            endcase
            cfg_write(8'(a), p);
        end
        for (int i = 0; i < 40; i++) begin
            arm = 8'($urandom_range(16, 31));
            if ($urandom_range(0, 4) == 0) begin
                p = 16'($urandom);
                run_action(arm, $urandom_range(0, 3), 1'b1, arm, p, 1'b0);
            end else begin
                run_action(arm, $urandom_range(0, 3), 1'b0, 8'd0, 16'h0, 1'b0);
            end
        end

        // Reset in RESPOND, then LFSR restarts from SEED: boundary prob
        // equal to the first stepped value hits, one below misses.
        run_action(8'd5, 2, 1'b0, 8'd0, 16'h0, 1'b1);
        chk("post_abort_action_ready", action_ready, 1);
        cfg_write(8'd7, model_step(SEED));
        run_action(8'd7, 0, 1'b0, 8'd0, 16'h0, 1'b0);
        chk("seed_step_equal_hit", reward_data, 16'h7FFF);
        run_action(8'd5, 0, 1'b0, 8'd0, 16'h0, 1'b1);
        cfg_write(8'd8, model_step(SEED) - 16'd1);
        run_action(8'd8, 0, 1'b0, 8'd0, 16'h0, 1'b0);
        chk("seed_step_below_miss", reward_data, 16'h0000);

        // Four pulls of the always-hit arm from a fresh reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_action(8'd5, 0, 1'b0, 8'd0, 16'h0, 1'b0);
        end
`ifdef BANDIT_ENV_STATS_EN
        chk("stats_pull_count_4", pull_count, 32'd4);
        chk("stats_reward_total_4", reward_total, 32'h0001_FFFC);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
